// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared memory.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the requesters plus the memory's read-data return.
interface mem_bus_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_gnt;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_gnt;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_ack, m1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_ack, m1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for a single-port
// memory. A request is latched at grant and held on the memory bus for
// ACCESS_CYCLES cycles. A one-cycle ack then follows, and a single IDLE
// cycle of bus turnaround comes after it. Every output is either a register
// or a decode of registered state, so req never reaches gnt in the same cycle.
module mem_bus_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_arbiter_if.slave    bus
);

  // A latency of 0 has no meaning for a registered access; run it as 1.
  localparam int N_EFF = (ACCESS_CYCLES < 1) ? 1 : ACCESS_CYCLES;
  localparam int CNT_W = $clog2(N_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_owner;       // 0 = m0, 1 = m1
  logic                  r_last_owner;  // owner of the last completed access
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic w_any_req;
  logic w_sel_owner;
  logic w_cnt_zero;
  logic w_in_access;
  logic w_in_done;

  assign w_any_req   = bus.m0_req | bus.m1_req;
  // m1 wins when it is alone, or on a tie when m0 owned the bus last.
  assign w_sel_owner = bus.m1_req & (~bus.m0_req | ~r_last_owner);
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_in_access = (r_state == ACCESS);
  assign w_in_done   = (r_state == DONE);

  // Arbitration, latching of the request, latency countdown and read capture.
  // NOTE: non-blocking assignments keep every register updating from the
  // values that existed before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner <= w_sel_owner;
            r_addr  <= w_sel_owner ? bus.m1_addr  : bus.m0_addr;
            r_wdata <= w_sel_owner ? bus.m1_wdata : bus.m0_wdata;
            r_we    <= w_sel_owner ? bus.m1_we    : bus.m0_we;
            r_cnt   <= CNT_INIT;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            if (!r_we) begin
              if (r_owner) r_rdata1 <= bus.mem_rdata;
              else         r_rdata0 <= bus.mem_rdata;
            end
            r_last_owner <= r_owner;
            r_state      <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from registered state only.
  assign bus.m0_gnt   = w_in_access & ~r_owner;
  assign bus.m1_gnt   = w_in_access &  r_owner;
  assign bus.m0_ack   = w_in_done   & ~r_owner;
  assign bus.m1_ack   = w_in_done   &  r_owner;
  assign bus.m0_rdata = r_rdata0;
  assign bus.m1_rdata = r_rdata1;

  // Memory bus carries the latched request only while accessing; the write
  // strobe is confined to the final access cycle.
  assign bus.mem_addr  = w_in_access ? r_addr  : '0;
  assign bus.mem_wdata = w_in_access ? r_wdata : '0;
  assign bus.mem_we    = w_in_access & r_we & w_cnt_zero;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a table of per-cycle vectors on an
// ACCESS_CYCLES=1 instance, plus hand-written sequences for the reset tie,
// the 3-cycle latency and an asynchronous reset during an access.
module tb_mem_bus_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic clk    = 1'b0;
  logic reset1 = 1'b1;
  logic reset3 = 1'b1;

  int total = 0;
  int bad   = 0;

  logic watch    = 1'b0;
  logic seen_bad = 1'b0;

  mem_bus_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
  mem_bus_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b3 ();

  mem_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACCESS_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (b1.slave)
  );

  mem_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACCESS_CYCLES(3)) dut3 (
    .clk   (clk),
    .reset (reset3),
    .bus   (b3.slave)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read; address 0x10 holds 0xDEADBEEF.
  assign b1.mem_rdata = (b1.mem_addr == 32'h10) ? 32'hDEAD_BEEF : (b1.mem_addr | 32'hC0DE_0000);
  assign b3.mem_rdata = b3.mem_addr | 32'hC0DE_0000;

  // Flags any write strobe or ack on the 3-cycle instance while watched.
  always @(posedge clk) begin
    if (watch && (b3.mem_we || b3.m0_ack || b3.m1_ack)) seen_bad <= 1'b1;
  end

  typedef struct {
    logic          m0_req;
    logic          m0_we;
    logic [31:0]   m0_addr;
    logic [31:0]   m0_wdata;
    logic          m1_req;
    logic          m1_we;
    logic [31:0]   m1_addr;
    logic [31:0]   m1_wdata;
    logic [3:0]    hs;      // {m0_gnt, m1_gnt, m0_ack, m1_ack}
    logic [31:0]   rd0;
    logic [31:0]   rd1;
    logic [31:0]   maddr;
    logic [31:0]   mwdata;
    logic          mwe;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act[164:0], exp[164:0]);
    end
  endtask

  function automatic logic [255:0] pack(input logic [3:0] hs, input logic [31:0] rd0,
                                        input logic [31:0] rd1, input logic [31:0] maddr,
                                        input logic [31:0] mwdata, input logic mwe);
    return {91'b0, hs, rd0, rd1, maddr, mwdata, mwe};
  endfunction

  function automatic logic [255:0] obs1();
    return pack({b1.m0_gnt, b1.m1_gnt, b1.m0_ack, b1.m1_ack},
                b1.m0_rdata, b1.m1_rdata, b1.mem_addr, b1.mem_wdata, b1.mem_we);
  endfunction

  function automatic logic [255:0] obs3();
    return pack({b3.m0_gnt, b3.m1_gnt, b3.m0_ack, b3.m1_ack},
                b3.m0_rdata, b3.m1_rdata, b3.mem_addr, b3.mem_wdata, b3.mem_we);
  endfunction

  task automatic apply1(input vec_t v);
    b1.m0_req   = v.m0_req;
    b1.m0_we    = v.m0_we;
    b1.m0_addr  = v.m0_addr;
    b1.m0_wdata = v.m0_wdata;
    b1.m1_req   = v.m1_req;
    b1.m1_we    = v.m1_we;
    b1.m1_addr  = v.m1_addr;
    b1.m1_wdata = v.m1_wdata;
  endtask

  task automatic idle_inputs();
    b1.m0_req = 0; b1.m0_we = 0; b1.m0_addr = '0; b1.m0_wdata = '0;
    b1.m1_req = 0; b1.m1_we = 0; b1.m1_addr = '0; b1.m1_wdata = '0;
    b3.m0_req = 0; b3.m0_we = 0; b3.m0_addr = '0; b3.m0_wdata = '0;
    b3.m1_req = 0; b3.m1_we = 0; b3.m1_addr = '0; b3.m1_wdata = '0;
  endtask

  initial begin
    // Each row: inputs applied before an edge, outputs expected after it.
    // m0 read of 0x10
    vecs[0]  = '{1, 0, 32'h10, 32'h0,       0, 0, 32'h0,  32'h0,       4'b1000, 32'h0,         32'h0,         32'h10, 32'h0,         0};
    vecs[1]  = '{1, 0, 32'h10, 32'h0,       0, 0, 32'h0,  32'h0,       4'b0010, 32'hDEAD_BEEF, 32'h0,         32'h0,  32'h0,         0};
    vecs[2]  = '{0, 0, 32'h0,  32'h0,       0, 0, 32'h0,  32'h0,       4'b0000, 32'hDEAD_BEEF, 32'h0,         32'h0,  32'h0,         0};
    // m1 write of 0x1234_5678 to 0x24
    vecs[3]  = '{0, 0, 32'h0,  32'h0,       1, 1, 32'h24, 32'h1234_5678, 4'b0100, 32'hDEAD_BEEF, 32'h0,       32'h24, 32'h1234_5678, 1};
    vecs[4]  = '{0, 0, 32'h0,  32'h0,       1, 1, 32'h24, 32'h1234_5678, 4'b0001, 32'hDEAD_BEEF, 32'h0,       32'h0,  32'h0,         0};
    vecs[5]  = '{0, 0, 32'h0,  32'h0,       0, 0, 32'h0,  32'h0,       4'b0000, 32'hDEAD_BEEF, 32'h0,         32'h0,  32'h0,         0};
    // 12 cycles of continuous contention, last owner m1 so m0 goes first
    vecs[6]  = '{1, 0, 32'h40, 32'h1111_1111, 1, 0, 32'h80, 32'h2222_2222, 4'b1000, 32'hDEAD_BEEF, 32'h0,         32'h40, 32'h1111_1111, 0};
    vecs[7]  = '{1, 0, 32'h40, 32'h1111_1111, 1, 0, 32'h80, 32'h2222_2222, 4'b0010, 32'hC0DE_0040, 32'h0,         32'h0,  32'h0,         0};
    vecs[8]  = '{1, 0, 32'h40, 32'h1111_1111, 1, 0, 32'h80, 32'h2222_2222, 4'b0000, 32'hC0DE_0040, 32'h0,         32'h0,  32'h0,         0};
    vecs[9]  = '{1, 0, 32'h40, 32'h1111_1111, 1, 0, 32'h80, 32'h2222_2222, 4'b0100, 32'hC0DE_0040, 32'h0,         32'h80, 32'h2222_2222, 0};
    vecs[10] = '{1, 0, 32'h40, 32'h1111_1111, 1, 0, 32'h80, 32'h2222_2222, 4'b0001, 32'hC0DE_0040, 32'hC0DE_0080, 32'h0,  32'h0,         0};
    vecs[11] = '{1, 0, 32'h44, 32'h1111_1111, 1, 0, 32'h80, 32'h2222_2222, 4'b0000, 32'hC0DE_0040, 32'hC0DE_0080, 32'h0,  32'h0,         0};
    vecs[12] = '{1, 0, 32'h44, 32'h1111_1111, 1, 0, 32'h80, 32'h2222_2222, 4'b1000, 32'hC0DE_0040, 32'hC0DE_0080, 32'h44, 32'h1111_1111, 0};
    vecs[13] = '{1, 0, 32'h44, 32'h1111_1111, 1, 0, 32'h80, 32'h2222_2222, 4'b0010, 32'hC0DE_0044, 32'hC0DE_0080, 32'h0,  32'h0,         0};
    vecs[14] = '{1, 0, 32'h44, 32'h1111_1111, 1, 0, 32'h84, 32'h2222_2222, 4'b0000, 32'hC0DE_0044, 32'hC0DE_0080, 32'h0,  32'h0,         0};
    vecs[15] = '{1, 0, 32'h44, 32'h1111_1111, 1, 0, 32'h84, 32'h2222_2222, 4'b0100, 32'hC0DE_0044, 32'hC0DE_0080, 32'h84, 32'h2222_2222, 0};
    vecs[16] = '{1, 0, 32'h44, 32'h1111_1111, 1, 0, 32'h84, 32'h2222_2222, 4'b0001, 32'hC0DE_0044, 32'hC0DE_0084, 32'h0,  32'h0,         0};
    vecs[17] = '{1, 0, 32'h44, 32'h1111_1111, 1, 0, 32'h84, 32'h2222_2222, 4'b0000, 32'hC0DE_0044, 32'hC0DE_0084, 32'h0,  32'h0,         0};
    vecs[18] = '{0, 0, 32'h0,  32'h0,       0, 0, 32'h0,  32'h0,       4'b0000, 32'hC0DE_0044, 32'hC0DE_0084, 32'h0,  32'h0,         0};
    // m0 write, request withdrawn and inputs changed right after grant
    vecs[19] = '{1, 1, 32'h50, 32'hAAAA_5555, 0, 0, 32'h0, 32'h0,      4'b1000, 32'hC0DE_0044, 32'hC0DE_0084, 32'h50, 32'hAAAA_5555, 1};
    vecs[20] = '{0, 0, 32'h99, 32'h0,       0, 0, 32'h0,  32'h0,       4'b0010, 32'hC0DE_0044, 32'hC0DE_0084, 32'h0,  32'h0,         0};
    vecs[21] = '{0, 0, 32'h0,  32'h0,       0, 0, 32'h0,  32'h0,       4'b0000, 32'hC0DE_0044, 32'hC0DE_0084, 32'h0,  32'h0,         0};

    idle_inputs();

    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    check("reset_n1", obs1(), pack(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0));
    check("reset_n3", obs3(), pack(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0));
    @(negedge clk);
    reset1 = 1'b0;
    reset3 = 1'b0;

    // Table-driven vectors on the single-cycle instance
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      apply1(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), obs1(),
            pack(vecs[i].hs, vecs[i].rd0, vecs[i].rd1, vecs[i].maddr, vecs[i].mwdata, vecs[i].mwe));
    end

    // Tie on the first IDLE cycle after reset: m0 first, m1 after turnaround
    @(negedge clk);
    reset1 = 1'b1;
    #1;
    check("tie_reset", obs1(), pack(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0));
    @(negedge clk);
    reset1 = 1'b0;
    b1.m0_req = 1; b1.m0_addr = 32'h60;
    b1.m1_req = 1; b1.m1_addr = 32'h70;
    @(posedge clk); #1;
    check("tie_m0_gnt", obs1(), pack(4'b1000, 32'h0, 32'h0, 32'h60, 32'h0, 1'b0));
    @(posedge clk); #1;
    check("tie_m0_ack", obs1(), pack(4'b0010, 32'hC0DE_0060, 32'h0, 32'h0, 32'h0, 1'b0));
    @(posedge clk); #1;
    check("tie_turn", obs1(), pack(4'b0000, 32'hC0DE_0060, 32'h0, 32'h0, 32'h0, 1'b0));
    @(posedge clk); #1;
    check("tie_m1_gnt", obs1(), pack(4'b0100, 32'hC0DE_0060, 32'h0, 32'h70, 32'h0, 1'b0));
    @(posedge clk); #1;
    check("tie_m1_ack", obs1(), pack(4'b0001, 32'hC0DE_0060, 32'hC0DE_0070, 32'h0, 32'h0, 1'b0));
    @(negedge clk);
    b1.m0_req = 0; b1.m1_req = 0;

    // ACCESS_CYCLES=3 write: address held three cycles, strobe on the third
    @(negedge clk);
    b3.m0_req = 1; b3.m0_we = 1; b3.m0_addr = 32'h30; b3.m0_wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    check("n3_acc1", obs3(), pack(4'b1000, 32'h0, 32'h0, 32'h30, 32'h0BAD_F00D, 1'b0));
    @(posedge clk); #1;
    check("n3_acc2", obs3(), pack(4'b1000, 32'h0, 32'h0, 32'h30, 32'h0BAD_F00D, 1'b0));
    @(posedge clk); #1;
    check("n3_acc3_we", obs3(), pack(4'b1000, 32'h0, 32'h0, 32'h30, 32'h0BAD_F00D, 1'b1));
    @(posedge clk); #1;
    check("n3_ack", obs3(), pack(4'b0010, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0));
    @(negedge clk);
    b3.m0_req = 0; b3.m0_we = 0;
    @(posedge clk); #1;
    check("n3_idle", obs3(), pack(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0));

    // Asynchronous reset in the second ACCESS cycle of a 3-cycle write
    @(negedge clk);
    b3.m0_req = 1; b3.m0_we = 1; b3.m0_addr = 32'h34; b3.m0_wdata = 32'h5A5A_5A5A;
    watch = 1'b1;
    @(posedge clk); #1;
    check("rst_pre", obs3(), pack(4'b1000, 32'h0, 32'h0, 32'h34, 32'h5A5A_5A5A, 1'b0));
    @(posedge clk); #2;
    reset3 = 1'b1;
    #1;
    check("rst_async", obs3(), pack(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0));
    @(negedge clk);
    b3.m0_req = 0; b3.m0_we = 0; b3.m0_wdata = '0;
    repeat (2) @(negedge clk);
    reset3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    watch = 1'b0;
    check("rst_no_we_ack", {255'b0, seen_bad}, 256'b0);
    check("rst_after", obs3(), pack(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0));

    // Tie after the aborted access: m0 must win
    @(negedge clk);
    b3.m0_req = 1; b3.m0_addr = 32'h34;
    b3.m1_req = 1; b3.m1_addr = 32'h38;
    @(posedge clk); #1;
    check("rst_tie_m0", obs3(), pack(4'b1000, 32'h0, 32'h0, 32'h34, 32'h0, 1'b0));
    @(negedge clk);
    b3.m0_req = 0; b3.m1_req = 0;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
